bios_flash_arbiter: RTL
=======================

BIOS_FLASH_ARBITER -- requirements
Module: bios_flash_arbiter

Interface
REQ-001 Parameter BOOT_TIMEOUT_MS, default 120, is the ms count of released-POR time after which the heartbeat is judged.
REQ-002 Parameter IDLE_CYCLES, default 16, is the count of consecutive clk cycles with host_csn high required before a flash switch commits.
REQ-003 Parameter POR_PULSE_MS, default 100, is the width of the CPU reset request pulse in ms ticks.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 tick_ms  in  1  single-cycle 1 ms strobe, synchronous to clk.
REQ-007 por_released  in  1  CPU POR deasserted, level.
REQ-008 hb_ok  in  1  BMC heartbeat present (deglitched), level.
REQ-009 upd_main_req / upd_second_req / upd_done  in  1 each  BMC update commands, active-high levels.
REQ-010 host_csn  in  1  CPU QSPI chip select, active-low.
REQ-011 csn0_out / csn1_out  out  1 each  chip selects to main / second flash, active-low.
REQ-012 por_req  out  1  CPU POR request, active-high.
REQ-013 state  out  2  committed state encoding.
REQ-014 switch_pending  out  1  a transition is waiting for bus idle.

Function
REQ-015 States: BIOS_MAIN=0, BIOS_SECOND=1, UPDATE_MAIN=2, UPDATE_SECOND=3; flash select = 0 for BIOS_MAIN/UPDATE_MAIN, 1 otherwise.
REQ-016 Boot timer: counts tick_ms while por_released=1 and state=BIOS_MAIN; clears when por_released=0 or on any commit; saturates at BOOT_TIMEOUT_MS; boot_done = (count==BOOT_TIMEOUT_MS).
REQ-017 BIOS_MAIN: boot_done & !hb_ok -> target BIOS_SECOND with POR; else boot_done & upd_second_req -> target UPDATE_SECOND, no POR; failover wins when both hold.
REQ-018 BIOS_SECOND: upd_main_req -> target UPDATE_MAIN, no POR.
REQ-019 UPDATE_MAIN / UPDATE_SECOND: upd_done -> target BIOS_MAIN with POR.
REQ-020 A decided target is latched and switch_pending asserted the next cycle; inputs are not re-evaluated while pending.
REQ-021 Idle counter: increments each cycle host_csn=1 while pending, clears on host_csn=0; commit occurs in the cycle it reaches IDLE_CYCLES; state updates on the following edge, switch_pending deasserts in the same edge.
REQ-022 csn0_out = (select==0) ? host_csn : 1; csn1_out = (select==1) ? host_csn : 1; select taken from committed state only, never from target.
REQ-023 POR pulse: on a commit marked POR, por_req asserts the next cycle and holds for POR_PULSE_MS tick_ms strobes; a new POR commit during a pulse restarts the count.
REQ-024 host_csn held low indefinitely: transition stays pending, outputs unchanged, no timeout.

Reset
REQ-025 rst asserted: state=BIOS_MAIN, switch_pending=0, por_req=0, all counters 0, csn0_out follows host_csn, csn1_out=1.
REQ-026 rst asserted mid-pending or mid-pulse abandons the transition and pulse immediately; no residual commit after release.

Configuration
REQ-027 Macro BIOS_ARB_CSN_BLANK_EN defined: both csn outputs forced 1 for IDLE_CYCLES clk cycles starting the cycle after each commit; undefined: no blanking, new mapping effective the cycle after commit.

Structure
REQ-028 Package bios_arb_pkg holds the state typedef and encodings, flash-select function, and parameter defaults.
REQ-029 One sub-module por_pulse_gen (tick-counted restartable pulse) is instantiated for por_req; all other logic lives in bios_flash_arbiter.

Verification
REQ-030 BOOT_TIMEOUT_MS=3, por_released=1, hb_ok=0, host_csn=1 -> commit to state=1 IDLE_CYCLES+1 cycles after 3rd tick; por_req high for exactly 100 ticks; csn1_out follows host_csn.
REQ-031 In BIOS_MAIN after boot_done, hb_ok=1, upd_second_req=1, host_csn toggling every 8 cycles -> switch_pending stays 1, state stays 0; host_csn held high 16 cycles -> state=3, por_req stays 0.
REQ-032 state=3, upd_done=1 -> state=0, por_req pulse; second POR commit injected at tick 50 -> pulse extends to tick 150.
REQ-033 boot_done, hb_ok=0 and upd_second_req=1 same cycle -> target BIOS_SECOND, por_req asserted.
REQ-034 rst pulsed while switch_pending=1 -> state=0, switch_pending=0, por_req=0, no later commit.
REQ-035 With BIOS_ARB_CSN_BLANK_EN: commit 0->1 -> csn0_out=csn1_out=1 for 16 cycles, then csn1_out follows host_csn.

Source files
------------

// File: rtl/bios_arb_pkg.sv
// bios_arb_pkg
//   Shared definitions for the BIOS flash arbiter slice: committed-state
//   encodings, the state -> flash-select mapping and parameter defaults.
package bios_arb_pkg;

   typedef enum logic [1:0] {
      BIOS_MAIN     = 2'd0,
      BIOS_SECOND   = 2'd1,
      UPDATE_MAIN   = 2'd2,
      UPDATE_SECOND = 2'd3
   } arb_state_e;

   localparam int unsigned BOOT_TIMEOUT_MS_DEF = 120;
   localparam int unsigned IDLE_CYCLES_DEF     = 16;
   localparam int unsigned POR_PULSE_MS_DEF    = 100;

   // 0 selects the main flash, 1 the second flash.
   function automatic logic flash_sel(input arb_state_e s);
      return (s == BIOS_SECOND) || (s == UPDATE_SECOND);
   endfunction

endpackage

// File: rtl/bios_flash_arbiter_por_pulse_gen.sv
// por_pulse_gen
//   Restartable pulse stretched over PULSE_TICKS tick strobes.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     start_i    single-cycle start; restarts the count if already active
//     tick_i     single-cycle ms strobe
//     pulse_o    high from the cycle after start_i until PULSE_TICKS ticks seen
module por_pulse_gen
   import bios_arb_pkg::*;
#(
   parameter int unsigned PULSE_TICKS = POR_PULSE_MS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic tick_i,
   output logic pulse_o
);

   localparam int unsigned CW = $clog2(PULSE_TICKS + 1);

   logic          active_q, active_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
      end
   end

   // A start coinciding with a tick takes priority: the count restarts at zero.
   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      if (start_i) begin
         active_d = 1'b1;
         cnt_d    = '0;
      end else if (active_q && tick_i) begin
         if (cnt_q == CW'(PULSE_TICKS - 1)) begin
            active_d = 1'b0;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign pulse_o = active_q;

endmodule

// File: rtl/bios_flash_arbiter.sv
// bios_flash_arbiter
//   Selects which BIOS flash the CPU QSPI chip select is routed to, fails over
//   to the second flash when the BMC heartbeat is missing after boot, and
//   sequences BMC-driven update modes. State switches only commit after the
//   QSPI bus has been idle for IDLE_CYCLES clocks.
//   Ports:
//     clk, rst                 50 MHz clock, asynchronous active-high reset
//     tick_ms                  1 ms strobe
//     por_released, hb_ok      CPU out of POR, BMC heartbeat present
//     upd_main_req, upd_second_req, upd_done   BMC update commands
//     host_csn                 CPU QSPI chip select (active-low)
//     csn0_out, csn1_out       chip selects to main / second flash
//     por_req                  CPU POR request pulse
//     state                    committed state
//     switch_pending           a transition waits for bus idle
//   Build option: BIOS_ARB_CSN_BLANK_EN forces both chip selects high for
//   IDLE_CYCLES clocks after every commit.
module bios_flash_arbiter
   import bios_arb_pkg::*;
#(
   parameter int unsigned BOOT_TIMEOUT_MS = BOOT_TIMEOUT_MS_DEF,
   parameter int unsigned IDLE_CYCLES     = IDLE_CYCLES_DEF,
   parameter int unsigned POR_PULSE_MS    = POR_PULSE_MS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_ms,
   input  logic       por_released,
   input  logic       hb_ok,
   input  logic       upd_main_req,
   input  logic       upd_second_req,
   input  logic       upd_done,
   input  logic       host_csn,
   output logic       csn0_out,
   output logic       csn1_out,
   output logic       por_req,
   output logic [1:0] state,
   output logic       switch_pending
);

   localparam int unsigned BW = $clog2(BOOT_TIMEOUT_MS + 1);
   localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);

   arb_state_e    state_q, state_d;
   arb_state_e    target_q, target_d;
   logic          pend_q, pend_d;
   logic          por_mark_q, por_mark_d;
   logic [BW-1:0] boot_cnt_q, boot_cnt_d;
   logic [IW-1:0] idle_cnt_q, idle_cnt_d;
   logic          boot_done;
   logic          commit;
   logic          blank;

   assign boot_done = (boot_cnt_q == BW'(BOOT_TIMEOUT_MS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= BIOS_MAIN;
         target_q   <= BIOS_MAIN;
         pend_q     <= 1'b0;
         por_mark_q <= 1'b0;
         boot_cnt_q <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         pend_q     <= pend_d;
         por_mark_q <= por_mark_d;
         boot_cnt_q <= boot_cnt_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   // Commit fires in the cycle whose idle increment would reach IDLE_CYCLES,
   // so the new state lands on that cycle's closing edge.
   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      pend_d     = pend_q;
      por_mark_d = por_mark_q;
      idle_cnt_d = idle_cnt_q;
      boot_cnt_d = boot_cnt_q;
      commit     = 1'b0;

      if (!por_released) begin
         boot_cnt_d = '0;
      end else if ((state_q == BIOS_MAIN) && tick_ms && !boot_done) begin
         boot_cnt_d = boot_cnt_q + BW'(1);
      end

      if (pend_q) begin
         if (host_csn) begin
            if (idle_cnt_q == IW'(IDLE_CYCLES - 1)) begin
               commit     = 1'b1;
               state_d    = target_q;
               pend_d     = 1'b0;
               idle_cnt_d = '0;
               boot_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + IW'(1);
            end
         end else begin
            idle_cnt_d = '0;
         end
      end else begin
         case (state_q)
            BIOS_MAIN: begin
               if (boot_done && !hb_ok) begin
                  target_d   = BIOS_SECOND;
                  por_mark_d = 1'b1;
                  pend_d     = 1'b1;
               end else if (boot_done && upd_second_req) begin
                  target_d   = UPDATE_SECOND;
                  por_mark_d = 1'b0;
                  pend_d     = 1'b1;
               end
            end
            BIOS_SECOND: begin
               if (upd_main_req) begin
                  target_d   = UPDATE_MAIN;
                  por_mark_d = 1'b0;
                  pend_d     = 1'b1;
               end
            end
            default: begin
               if (upd_done) begin
                  target_d   = BIOS_MAIN;
                  por_mark_d = 1'b1;
                  pend_d     = 1'b1;
               end
            end
         endcase
      end
   end

`ifdef BIOS_ARB_CSN_BLANK_EN
   logic [IW-1:0] blank_cnt_q, blank_cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) blank_cnt_q <= '0;
      else     blank_cnt_q <= blank_cnt_d;
   end

   always_comb begin
      blank_cnt_d = blank_cnt_q;
      if (commit)                  blank_cnt_d = IW'(IDLE_CYCLES);
      else if (blank_cnt_q != '0)  blank_cnt_d = blank_cnt_q - IW'(1);
   end

   assign blank = (blank_cnt_q != '0);
`else
   assign blank = 1'b0;
`endif

   // Routing uses the committed state only, never the pending target.
   always_comb begin
      csn0_out = 1'b1;
      csn1_out = 1'b1;
      if (!blank) begin
         if (flash_sel(state_q)) csn1_out = host_csn;
         else                    csn0_out = host_csn;
      end
   end

   assign state          = state_q;
   assign switch_pending = pend_q;

   por_pulse_gen #(
      .PULSE_TICKS(POR_PULSE_MS)
   ) u_por (
      .clk    (clk),
      .rst    (rst),
      .start_i(commit && por_mark_q),
      .tick_i (tick_ms),
      .pulse_o(por_req)
   );

endmodule
